muldiv_seq: RTL

Multi-cycle sequencer for the execute stage's multiply and divide operations (MUL, SMULL, UMULL, UDIV). The pipeline hands it one operation at a time with a start/done handshake and stalls on `busy`. It replaces single-cycle `*` and `/` in the ALU with a 32-iteration shift-add multiplier and a restoring divider, both owned and sequenced by this block. Results return on the same low/high (`result`/`long`) split the ALU uses.

---
 rtl/muldiv_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer for the execute stage: 32-iteration
// shift-add multiplier and restoring divider behind a start/done handshake.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] long,
  output logic [3:0]  flags,
  output logic        dbz
);

  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b110;
  localparam logic [2:0] OP_UMULL = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Working registers
  logic [31:0] mcand;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [32:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [4:0]  count;
  logic        sign_q;

  logic        accept;
  logic        is_div;
  logic        div_zero;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_sub;
  logic        div_ge;

  logic [63:0] prod;
  logic [31:0] fin_lo;
  logic [31:0] fin_hi;
  logic [3:0]  fin_flags;

  function automatic logic [31:0] magnitude(input logic signed [31:0] x);
    logic signed [31:0] m;
    m = (x < 0) ? -x : x;
    return $unsigned(m);
  endfunction

  function automatic logic [63:0] negate64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  assign accept   = start && op[2] && !flush && (state == IDLE || state == DONE);
  assign is_div   = (op_q == OP_UDIV);
  assign div_zero = is_div && (b_q == 32'd0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SETUP;
        SETUP:   state_nxt = div_zero ? FIX : RUN;
        RUN:     if (count == 5'd31) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = accept ? SETUP : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SETUP, RUN, FIX: busy = 1'b1;
      DONE:            done = 1'b1;
      default:         ;
    endcase
  end

  // One iteration of each datapath
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : 33'd0);
  assign div_shift = {rem[31:0], dvd[31]};
  assign div_ge    = (div_shift >= {1'b0, dvs});
  assign div_sub   = div_shift - {1'b0, dvs};

  // Final correction applied in FIX
  assign prod = {p_hi, p_lo};

  always_comb begin
    fin_lo = 32'd0;
    fin_hi = 32'd0;
    case (op_q)
      OP_SMULL: {fin_hi, fin_lo} = sign_q ? negate64(prod) : prod;
      OP_UMULL: {fin_hi, fin_lo} = prod;
      OP_MUL:   fin_lo = p_lo;
      OP_UDIV: begin
        if (b_q == 32'd0) begin
          fin_lo = 32'd0;
          fin_hi = a_q;
        end else begin
          fin_lo = dvd;
          fin_hi = rem[31:0];
        end
      end
      default: ;
    endcase
  end

  // op[1] distinguishes the long multiplies from MUL/UDIV
  always_comb begin
    fin_flags = 4'b0000;
    if (op_q[1]) begin
      fin_flags[3] = fin_hi[31];
      fin_flags[2] = ({fin_hi, fin_lo} == 64'd0);
    end else begin
      fin_flags[3] = fin_lo[31];
      fin_flags[2] = (fin_lo == 32'd0);
    end
  end

  // Request latch, working registers and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      mcand  <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      rem    <= 33'd0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      count  <= 5'd0;
      sign_q <= 1'b0;
      result <= 32'd0;
      long   <= 32'd0;
      flags  <= 4'd0;
      dbz    <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      if (!flush) begin
        case (state)
          SETUP: begin
            count  <= 5'd0;
            sign_q <= (op_q == OP_SMULL) && (a_q[31] ^ b_q[31]);
            if (is_div) begin
              dvd <= a_q;
              dvs <= b_q;
              rem <= 33'd0;
            end else if (op_q == OP_SMULL) begin
              mcand <= magnitude($signed(a_q));
              p_lo  <= magnitude($signed(b_q));
              p_hi  <= 32'd0;
            end else begin
              mcand <= a_q;
              p_lo  <= b_q;
              p_hi  <= 32'd0;
            end
          end
          RUN: begin
            count <= count + 5'd1;
            if (is_div) begin
              rem <= div_ge ? div_sub : div_shift;
              dvd <= {dvd[30:0], div_ge};
            end else begin
              p_hi <= mul_sum[32:1];
              p_lo <= {mul_sum[0], p_lo[31:1]};
            end
          end
          FIX: begin
            result <= fin_lo;
            long   <= fin_hi;
            flags  <= fin_flags;
            if (is_div) dbz <= (b_q == 32'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
